// File: rtl/rmgmt_ext_iter_execute.sv
// Execute-stage extension unit on the ext side of the RISC-MGMT execute
// interface. It implements three custom instructions:
// - iterative shift-add multiply (low word), using the core ALU for each add;
// - iterative popcount;
// - single-cycle decrement-and-branch loop.
// All outputs are combinational from the current state and the inputs.
module rmgmt_ext_iter_execute #(
  parameter bit MUL_EARLY_EXIT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        flush,
  input  logic [31:0] rdata_s_0,
  input  logic [31:0] rdata_s_1,
  input  logic [31:0] alu_res,
  output logic        exception,
  output logic        busy,
  output logic        reg_w,
  output logic [31:0] reg_wdata,
  output logic        branch_jump,
  output logic [31:0] br_j_addr,
  output logic        alu_access,
  output logic [31:0] alu_data_0,
  output logic [31:0] alu_data_1,
  output logic [3:0]  alu_op
);

  // Core ALU operation codes; ALU_ADD doubles as the idle value.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOOP = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_POP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q,  state_d;
  logic [31:0] mcand_q,  mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q,    acc_d;
  logic [4:0]  cnt_q,    cnt_d;

  logic        iter_last;
  logic [31:0] loop_target;

  // The iteration that shifts the last set bit out, or the 32nd one, is final.
  assign iter_last   = (cnt_q == 5'd31) ||
                       (MUL_EARLY_EXIT && (mplier_q[31:1] == 31'd0));
  assign loop_target = pc + imm;

  // Next-state, datapath and output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    exception   = 1'b0;
    busy        = 1'b0;
    reg_w       = 1'b0;
    reg_wdata   = 32'd0;
    branch_jump = 1'b0;
    br_j_addr   = 32'd0;
    alu_access  = 1'b0;
    alu_data_0  = 32'd0;
    alu_data_1  = 32'd0;
    alu_op      = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MUL: begin
              mcand_d  = rdata_s_0;
              mplier_d = rdata_s_1;
              acc_d    = 32'd0;
              cnt_d    = 5'd0;
              busy     = 1'b1;
              state_d  = (MUL_EARLY_EXIT && rdata_s_1 == 32'd0) ? S_DONE : S_MUL;
            end
            OP_POP: begin
              mplier_d = rdata_s_0;
              acc_d    = 32'd0;
              cnt_d    = 5'd0;
              busy     = 1'b1;
              state_d  = (MUL_EARLY_EXIT && rdata_s_0 == 32'd0) ? S_DONE : S_POP;
            end
            OP_LOOP: begin
              alu_access  = 1'b1;
              alu_data_0  = rdata_s_0;
              alu_data_1  = 32'd1;
              alu_op      = ALU_SUB;
              reg_w       = 1'b1;
              reg_wdata   = alu_res;
              branch_jump = (alu_res != 32'd0);
              br_j_addr   = branch_jump ? loop_target : 32'd0;
            end
            default: begin
              exception = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (mplier_q[0]) begin
          alu_access = 1'b1;
          alu_data_0 = acc_q;
          alu_data_1 = mcand_q;
          alu_op     = ALU_ADD;
          acc_d      = alu_res;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (iter_last) state_d = S_DONE;
      end
      S_POP: begin
        busy     = 1'b1;
        acc_d    = acc_q + {31'd0, mplier_q[0]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (iter_last) state_d = S_DONE;
      end
      default: begin
        // DONE: the finishing instruction still sits in execute, so start is ignored.
        reg_w     = 1'b1;
        reg_wdata = acc_q;
        state_d   = S_IDLE;
      end
    endcase

    // A flush abandons whatever is in flight and suppresses its side effects.
    if (flush) begin
      state_d     = S_IDLE;
      reg_w       = 1'b0;
      exception   = 1'b0;
      branch_jump = 1'b0;
      br_j_addr   = 32'd0;
      busy        = 1'b0;
    end

    // Reset wins over everything and forces every output to its idle value.
    if (RST) begin
      exception   = 1'b0;
      busy        = 1'b0;
      reg_w       = 1'b0;
      reg_wdata   = 32'd0;
      branch_jump = 1'b0;
      br_j_addr   = 32'd0;
      alu_access  = 1'b0;
      alu_data_0  = 32'd0;
      alu_data_1  = 32'd0;
      alu_op      = ALU_ADD;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples its pre-edge _d value.
    if (RST) begin
      state_q  <= S_IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
